// File: rtl/branch_resolve_updater_pkg.sv
// Shared types and helpers for the branch resolve / predictor update block.
// Lane records, FSM states and the misprediction/next-PC rules live here.
package branch_resolve_pkg;

  localparam int PKG_SIZE       = 32;
  localparam int PKG_ROB_IDX_W  = 5;
  localparam int PKG_RAS_PTR_W  = 3;
  localparam int RECOVER_CYCLES_DEF = 2;
  localparam int NUM_LANES      = 3;

  typedef struct packed {
    logic                     valid;
    logic [PKG_SIZE-1:0]      pc;
    logic                     is_branch;
    logic                     is_jalr;
    logic                     is_jal;
    logic                     pred_taken;
    logic [PKG_SIZE-1:0]      pred_target;
    logic                     actual_taken;
    logic [PKG_SIZE-1:0]      actual_target;
    logic [PKG_ROB_IDX_W-1:0] rob_idx;
    logic [PKG_RAS_PTR_W-1:0] ras_tos;
  } resolve_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } upd_state_e;

  // Unconditional jumps are always taken, so only the target can be wrong.
  function automatic logic lane_mispredict(resolve_t r);
    if (r.is_branch)
      return (r.pred_taken != r.actual_taken) ||
             (r.actual_taken && (r.pred_target != r.actual_target));
    if (r.is_jal || r.is_jalr)
      return r.pred_target != r.actual_target;
    return 1'b0;
  endfunction

  function automatic logic [PKG_SIZE-1:0] lane_correct_pc(resolve_t r);
    return r.actual_taken ? r.actual_target : r.pc + PKG_SIZE'(4);
  endfunction

endpackage

// File: rtl/branch_resolve_updater_if.sv
// Resolve bundle from the FUs plus the predictor update / redirect bundle.
// The updater uses the slave modport; the FU side (or a bench) uses master.
interface branch_resolve_if
  import branch_resolve_pkg::*;
#(
  parameter int size      = PKG_SIZE,
  parameter int ROB_IDX_W = PKG_ROB_IDX_W,
  parameter int RAS_PTR_W = PKG_RAS_PTR_W
);
  logic [NUM_LANES-1:0] resolve_valid_i;
  logic [size-1:0]      resolve_pc_i [NUM_LANES];
  logic [NUM_LANES-1:0] resolve_is_branch_i;
  logic [NUM_LANES-1:0] resolve_is_jalr_i;
  logic [NUM_LANES-1:0] resolve_is_jal_i;
  logic [NUM_LANES-1:0] pred_taken_i;
  logic [size-1:0]      pred_target_i [NUM_LANES];
  logic [NUM_LANES-1:0] actual_taken_i;
  logic [size-1:0]      actual_target_i [NUM_LANES];
  logic [ROB_IDX_W-1:0] rob_idx_i [NUM_LANES];
  logic [RAS_PTR_W-1:0] ras_tos_i [NUM_LANES];

  logic [size-1:0]      update_prediction_pc [NUM_LANES];
  logic [NUM_LANES-1:0] update_prediction_valid_o;
  logic [NUM_LANES-1:0] misprediction;
  logic [size-1:0]      correct_pc [NUM_LANES];
  logic [NUM_LANES-1:0] jalr_update_valid;
  logic [size-1:0]      jalr_update_prediction_pc [NUM_LANES];
  logic                 ras_restore_en_o;
  logic [RAS_PTR_W-1:0] ras_restore_tos_o;
  logic                 flush_o;
  logic [size-1:0]      redirect_pc_o;
  logic                 recovering_o;

  modport master (
    output resolve_valid_i, resolve_pc_i, resolve_is_branch_i, resolve_is_jalr_i,
           resolve_is_jal_i, pred_taken_i, pred_target_i, actual_taken_i,
           actual_target_i, rob_idx_i, ras_tos_i,
    input  update_prediction_pc, update_prediction_valid_o, misprediction, correct_pc,
           jalr_update_valid, jalr_update_prediction_pc, ras_restore_en_o,
           ras_restore_tos_o, flush_o, redirect_pc_o, recovering_o
  );

  modport slave (
    input  resolve_valid_i, resolve_pc_i, resolve_is_branch_i, resolve_is_jalr_i,
           resolve_is_jal_i, pred_taken_i, pred_target_i, actual_taken_i,
           actual_target_i, rob_idx_i, ras_tos_i,
    output update_prediction_pc, update_prediction_valid_o, misprediction, correct_pc,
           jalr_update_valid, jalr_update_prediction_pc, ras_restore_en_o,
           ras_restore_tos_o, flush_o, redirect_pc_o, recovering_o
  );
endinterface

// File: rtl/branch_resolve_updater_rob_age_compare.sv
// Age comparator: a is strictly older than b when its distance from the ROB
// head is smaller, with both distances taken modulo the index width.
module rob_age_compare #(
  parameter int ROB_IDX_W = 5
) (
  input  logic [ROB_IDX_W-1:0] idx_a,
  input  logic [ROB_IDX_W-1:0] idx_b,
  input  logic [ROB_IDX_W-1:0] head,
  output logic                 a_older
);
  logic [ROB_IDX_W-1:0] age_a;
  logic [ROB_IDX_W-1:0] age_b;

  assign age_a   = idx_a - head;
  assign age_b   = idx_b - head;
  assign a_older = age_a < age_b;
endmodule

// File: rtl/branch_resolve_updater.sv
// Classifies FU branch/jump resolves, drives registered predictor updates and
// a single redirect for the oldest mispredict, then filters squashed resolves.
module branch_resolve_updater
  import branch_resolve_pkg::*;
#(
  parameter int size           = PKG_SIZE,
  parameter int ROB_IDX_W      = PKG_ROB_IDX_W,
  parameter int RAS_PTR_W      = PKG_RAS_PTR_W,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROB_IDX_W-1:0] rob_head_i,
  branch_resolve_if.slave      rif
);
  localparam int CNT_W = $clog2(RECOVER_CYCLES + 1);

  resolve_t [NUM_LANES-1:0]           lane;
  logic [NUM_LANES-1:0]               lane_mp;
  logic [size-1:0]                    lane_cpc [NUM_LANES];
  logic [NUM_LANES-1:0]               flush_older;
  logic [NUM_LANES-1:0]               cand;
  logic [NUM_LANES-1:0]               mp_cand;
  logic [NUM_LANES-1:0]               win;
  logic [NUM_LANES-1:0]               live;
  // older_lane[a][b]: lane a is older than lane b (ties favour the lower lane)
  logic [NUM_LANES-1:0][NUM_LANES-1:0] older_lane;

  logic                 any_win;
  logic [ROB_IDX_W-1:0] w_rob;
  logic [size-1:0]      w_cpc;
  logic [RAS_PTR_W-1:0] w_tos;

  upd_state_e           state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [ROB_IDX_W-1:0] flush_rob_reg, flush_rob_next;

  logic [NUM_LANES-1:0] upd_valid_reg, upd_valid_next;
  logic [NUM_LANES-1:0] mispred_reg, mispred_next;
  logic [NUM_LANES-1:0] jalr_valid_reg, jalr_valid_next;
  logic [size-1:0]      upd_pc_reg [NUM_LANES];
  logic [size-1:0]      upd_pc_next [NUM_LANES];
  logic [size-1:0]      cpc_reg [NUM_LANES];
  logic [size-1:0]      cpc_next [NUM_LANES];
  logic [size-1:0]      jalr_pc_reg [NUM_LANES];
  logic [size-1:0]      jalr_pc_next [NUM_LANES];
  logic                 flush_reg, flush_next;
  logic [size-1:0]      redirect_reg, redirect_next;
  logic                 ras_en_reg, ras_en_next;
  logic [RAS_PTR_W-1:0] ras_tos_reg, ras_tos_next;

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      lane[k].valid         = rif.resolve_valid_i[k];
      lane[k].pc            = rif.resolve_pc_i[k];
      lane[k].is_branch     = rif.resolve_is_branch_i[k];
      lane[k].is_jalr       = rif.resolve_is_jalr_i[k];
      lane[k].is_jal        = rif.resolve_is_jal_i[k];
      lane[k].pred_taken    = rif.pred_taken_i[k];
      lane[k].pred_target   = rif.pred_target_i[k];
      lane[k].actual_taken  = rif.actual_taken_i[k];
      lane[k].actual_target = rif.actual_target_i[k];
      lane[k].rob_idx       = rif.rob_idx_i[k];
      lane[k].ras_tos       = rif.ras_tos_i[k];
      lane_mp[k]            = lane_mispredict(lane[k]);
      lane_cpc[k]           = lane_correct_pc(lane[k]);
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      // Age is recomputed against the current head every cycle.
      rob_age_compare #(.ROB_IDX_W(ROB_IDX_W)) u_flush_age (
        .idx_a   (lane[gi].rob_idx),
        .idx_b   (flush_rob_reg),
        .head    (rob_head_i),
        .a_older (flush_older[gi])
      );

      assign older_lane[gi][gi] = 1'b0;
      assign cand[gi]    = lane[gi].valid && ((state_reg == IDLE) || flush_older[gi]);
      assign mp_cand[gi] = cand[gi] && lane_mp[gi];

      for (gj = gi + 1; gj < NUM_LANES; gj++) begin : g_pair
        logic hi_older;
        rob_age_compare #(.ROB_IDX_W(ROB_IDX_W)) u_pair_age (
          .idx_a   (lane[gj].rob_idx),
          .idx_b   (lane[gi].rob_idx),
          .head    (rob_head_i),
          .a_older (hi_older)
        );
        assign older_lane[gi][gj] = ~hi_older;
        assign older_lane[gj][gi] = hi_older;
      end
    end
  endgenerate

  // Oldest mispredicting candidate, then squash everything younger than it.
  always_comb begin
    win = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      win[k] = mp_cand[k];
      for (int m = 0; m < NUM_LANES; m++)
        if (m != k && mp_cand[m] && !older_lane[k][m]) win[k] = 1'b0;
    end
  end

  always_comb begin
    live = cand;
    for (int k = 0; k < NUM_LANES; k++)
      for (int w = 0; w < NUM_LANES; w++)
        if (win[w] && older_lane[w][k]) live[k] = 1'b0;
  end

  always_comb begin
    any_win = |win;
    w_rob   = '0;
    w_cpc   = '0;
    w_tos   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (win[k]) begin
        w_rob = lane[k].rob_idx;
        w_cpc = lane_cpc[k];
        w_tos = lane[k].ras_tos;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    flush_rob_next = flush_rob_reg;
    if (any_win) begin
      state_next     = RECOVER;
      cnt_next       = CNT_W'(RECOVER_CYCLES);
      flush_rob_next = w_rob;
    end else if (state_reg == RECOVER) begin
      cnt_next = cnt_reg - 1'b1;
      if (cnt_reg == CNT_W'(1)) state_next = IDLE;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      upd_valid_next[k]  = live[k] && lane[k].is_branch;
      jalr_valid_next[k] = live[k] && lane[k].is_jalr;
      mispred_next[k]    = live[k] && lane_mp[k];
      upd_pc_next[k]     = live[k] ? lane[k].pc : '0;
      jalr_pc_next[k]    = live[k] ? lane[k].pc : '0;
      cpc_next[k]        = live[k] ? lane_cpc[k] : '0;
    end
    flush_next    = any_win;
    redirect_next = w_cpc;
    ras_en_next   = any_win;
    ras_tos_next  = w_tos;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      flush_rob_reg  <= '0;
      upd_valid_reg  <= '0;
      mispred_reg    <= '0;
      jalr_valid_reg <= '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        upd_pc_reg[k]  <= '0;
        jalr_pc_reg[k] <= '0;
        cpc_reg[k]     <= '0;
      end
      flush_reg      <= 1'b0;
      redirect_reg   <= '0;
      ras_en_reg     <= 1'b0;
      ras_tos_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      flush_rob_reg  <= flush_rob_next;
      upd_valid_reg  <= upd_valid_next;
      mispred_reg    <= mispred_next;
      jalr_valid_reg <= jalr_valid_next;
      for (int k = 0; k < NUM_LANES; k++) begin
        upd_pc_reg[k]  <= upd_pc_next[k];
        jalr_pc_reg[k] <= jalr_pc_next[k];
        cpc_reg[k]     <= cpc_next[k];
      end
      flush_reg      <= flush_next;
      redirect_reg   <= redirect_next;
      ras_en_reg     <= ras_en_next;
      ras_tos_reg    <= ras_tos_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_out
      assign rif.update_prediction_pc[gi]      = upd_pc_reg[gi];
      assign rif.correct_pc[gi]                = cpc_reg[gi];
      assign rif.jalr_update_prediction_pc[gi] = jalr_pc_reg[gi];
    end
  endgenerate

  assign rif.update_prediction_valid_o = upd_valid_reg;
  assign rif.misprediction             = mispred_reg;
  assign rif.jalr_update_valid         = jalr_valid_reg;
  assign rif.ras_restore_en_o          = ras_en_reg;
  assign rif.ras_restore_tos_o         = ras_tos_reg;
  assign rif.flush_o                   = flush_reg;
  assign rif.redirect_pc_o             = redirect_reg;
  assign rif.recovering_o              = (state_reg == RECOVER);

endmodule
